// File: rtl/xor_accum.sv
// Streaming LRC: XOR-folds a frame of N-bit words, then holds LRC, parity and a
// saturating word count on a valid/ready result port until the consumer takes it.
module xor_accum #(
    parameter int N    = 8,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            odd,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_lrc,
    output logic            out_parity,
    output logic [CNTW-1:0] out_count,
    output logic            out_ovf,
    output logic            state_dbg
);

    // Handshakes: a beat transfers on a cycle where valid and ready are both 1;
    // valid never waits on ready, and in_ready is forced low while in reset.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t          state_q, state_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;
    logic [N-1:0]    lrc_q, lrc_d;
    logic            par_q, par_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            oovf_q, oovf_d;

    logic            beat;
    logic            cnt_full;
    logic [CNTW-1:0] cnt_inc;
    logic [N-1:0]    acc_nxt;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        lrc_d    = lrc_q;
        par_d    = par_q;
        count_d  = count_q;
        oovf_d   = oovf_q;

        in_ready = (state_q == ACCUM) && rst_n;
        beat     = in_valid && in_ready;
        cnt_full = (cnt_q == CNT_MAX);
        cnt_inc  = cnt_full ? cnt_q : cnt_q + CNTW'(1);
        acc_nxt  = acc_q ^ in_data;

        case (state_q)
            ACCUM: begin
                if (beat) begin
                    if (in_last) begin
                        lrc_d   = acc_nxt;
                        count_d = cnt_inc;
                        oovf_d  = ovf_q | cnt_full;
                        par_d   = (^acc_nxt) ^ odd;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        acc_d   = acc_nxt;
                        cnt_d   = cnt_inc;
                        // Overflow is sticky until the frame closes.
                        ovf_d   = ovf_q | cnt_full;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            lrc_q   <= '0;
            par_q   <= 1'b0;
            count_q <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            lrc_q   <= lrc_d;
            par_q   <= par_d;
            count_q <= count_d;
            oovf_q  <= oovf_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_lrc    = lrc_q;
    assign out_parity = par_q;
    assign out_count  = count_q;
    assign out_ovf    = oovf_q;
    assign state_dbg  = (state_q == HOLD);

endmodule

// File: tb/tb_xor_accum.sv
// Bench for xor_accum: an 8-bit/8-bit-count and an 8-bit/2-bit-count instance share
// one stimulus stream; a frame-level model plus a directed vector table check both.
module tb_xor_accum;

  logic       clk = 1'b0;
  logic       rst_n, odd, in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic       in_ready_a, out_valid_a, out_parity_a, out_ovf_a, state_a;
  logic [7:0] out_lrc_a, out_count_a;
  logic       in_ready_b, out_valid_b, out_parity_b, out_ovf_b, state_b;
  logic [7:0] out_lrc_b;
  logic [1:0] out_count_b;

  always #5 clk = ~clk;

  xor_accum #(.N(8), .CNTW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .odd(odd), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_lrc(out_lrc_a), .out_parity(out_parity_a), .out_count(out_count_a),
    .out_ovf(out_ovf_a), .state_dbg(state_a)
  );

  xor_accum #(.N(8), .CNTW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .odd(odd), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_lrc(out_lrc_b), .out_parity(out_parity_b), .out_count(out_count_b),
    .out_ovf(out_ovf_b), .state_dbg(state_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: words of the open frame, plus the last reported result.
  logic [7:0] m_words[$];
  logic       m_hold = 1'b0;
  logic [7:0] m_lrc = '0;
  logic       m_par = 1'b0;
  logic [7:0] m_cnt_a = '0;
  logic       m_ovf_a = 1'b0;
  logic [1:0] m_cnt_b = '0;
  logic       m_ovf_b = 1'b0;

  task automatic close_frame(input logic o);
    int ones = 0;
    int len;
    m_lrc = '0;
    foreach (m_words[i]) begin
      m_lrc = m_lrc ^ m_words[i];
      ones  = ones + $countones(m_words[i]);
    end
    len     = m_words.size();
    m_par   = (ones % 2 == 1) ^ o;
    m_cnt_a = (len > 255) ? 8'd255 : 8'(len);
    m_ovf_a = (len > 255);
    m_cnt_b = (len > 3) ? 2'd3 : 2'(len);
    m_ovf_b = (len > 3);
    m_words.delete();
    m_hold  = 1'b1;
  endtask

  // One clock: drive inputs, check in_ready, advance the model at the edge,
  // then compare every output of both instances on the falling edge.
  task automatic drive(input logic r, input logic v, input logic [7:0] d,
                       input logic l, input logic o, input logic rdy);
    logic exp_rdy;
    rst_n = r; in_valid = v; in_data = d; in_last = l; odd = o; out_ready = rdy;
    #1;
    exp_rdy = r && !m_hold;
    chk("in_ready_a", {31'd0, in_ready_a}, {31'd0, exp_rdy});
    chk("in_ready_b", {31'd0, in_ready_b}, {31'd0, exp_rdy});
    @(posedge clk);
    if (!r) begin
      m_words.delete();
      m_hold = 1'b0; m_lrc = '0; m_par = 1'b0;
      m_cnt_a = '0; m_ovf_a = 1'b0; m_cnt_b = '0; m_ovf_b = 1'b0;
    end else if (!m_hold) begin
      if (v) begin
        m_words.push_back(d);
        if (l) close_frame(o);
      end
    end else if (rdy) begin
      m_hold = 1'b0;
    end
    @(negedge clk);
    chk("outs_a", {12'd0, out_valid_a, state_a, out_lrc_a, out_parity_a, out_count_a, out_ovf_a},
                  {12'd0, m_hold, m_hold, m_lrc, m_par, m_cnt_a, m_ovf_a});
    chk("outs_b", {18'd0, out_valid_b, state_b, out_lrc_b, out_parity_b, out_count_b, out_ovf_b},
                  {18'd0, m_hold, m_hold, m_lrc, m_par, m_cnt_b, m_ovf_b});
  endtask

  typedef struct {
    logic       r, v;
    logic [7:0] d;
    logic       l, o, rdy;
    logic       e_valid;
    logic [7:0] e_lrc;
    logic       e_par;
    logic [7:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic l,
                     input logic o, input logic rdy, input logic ev, input logic [7:0] el,
                     input logic ep, input logic [7:0] ec, input logic eo);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.l = l; t.o = o; t.rdy = rdy;
    t.e_valid = ev; t.e_lrc = el; t.e_par = ep; t.e_cnt = ec; t.e_ovf = eo;
    tbl.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; odd = 1'b0; out_ready = 1'b0;

    //   r  v  data   l  o  rdy | valid lrc   par cnt ovf   (dut_a, after the edge)
    add(0, 1, 8'h99, 1, 0, 0,    0, 8'h00, 0, 8'd0, 0);
    add(0, 1, 8'h99, 1, 0, 0,    0, 8'h00, 0, 8'd0, 0);
    add(1, 0, 8'h00, 0, 0, 1,    0, 8'h00, 0, 8'd0, 0);
    add(1, 1, 8'h12, 0, 0, 1,    0, 8'h00, 0, 8'd0, 0);
    add(1, 1, 8'h34, 0, 0, 1,    0, 8'h00, 0, 8'd0, 0);
    add(1, 1, 8'h56, 1, 0, 1,    1, 8'h70, 1, 8'd3, 0);
    add(1, 0, 8'h00, 0, 0, 1,    0, 8'h70, 1, 8'd3, 0);
    add(1, 1, 8'h12, 0, 0, 1,    0, 8'h70, 1, 8'd3, 0);
    add(1, 1, 8'h34, 0, 0, 1,    0, 8'h70, 1, 8'd3, 0);
    add(1, 1, 8'h56, 1, 1, 1,    1, 8'h70, 0, 8'd3, 0);
    add(1, 0, 8'h00, 0, 0, 1,    0, 8'h70, 0, 8'd3, 0);
    add(1, 1, 8'hFF, 1, 0, 0,    1, 8'hFF, 0, 8'd1, 0);
    add(1, 1, 8'hA5, 1, 1, 0,    1, 8'hFF, 0, 8'd1, 0);
    add(1, 1, 8'h5A, 0, 0, 0,    1, 8'hFF, 0, 8'd1, 0);
    add(1, 1, 8'hA5, 1, 1, 0,    1, 8'hFF, 0, 8'd1, 0);
    add(1, 1, 8'h5A, 0, 0, 0,    1, 8'hFF, 0, 8'd1, 0);
    add(1, 1, 8'hA5, 1, 1, 0,    1, 8'hFF, 0, 8'd1, 0);
    add(1, 1, 8'h33, 1, 0, 1,    0, 8'hFF, 0, 8'd1, 0);
    add(1, 1, 8'h0C, 1, 0, 1,    1, 8'h0C, 0, 8'd1, 0);
    add(1, 0, 8'h00, 0, 0, 1,    0, 8'h0C, 0, 8'd1, 0);
    add(1, 1, 8'hAA, 0, 0, 1,    0, 8'h0C, 0, 8'd1, 0);
    add(1, 1, 8'h55, 0, 0, 1,    0, 8'h0C, 0, 8'd1, 0);
    add(0, 0, 8'h00, 0, 0, 1,    0, 8'h00, 0, 8'd0, 0);
    add(1, 1, 8'h0F, 1, 0, 1,    1, 8'h0F, 0, 8'd1, 0);
    add(1, 0, 8'h00, 0, 0, 1,    0, 8'h0F, 0, 8'd1, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].o, tbl[i].rdy);
      chk($sformatf("tbl[%0d]", i),
          {13'd0, out_valid_a, out_lrc_a, out_parity_a, out_count_a, out_ovf_a},
          {13'd0, tbl[i].e_valid, tbl[i].e_lrc, tbl[i].e_par, tbl[i].e_cnt, tbl[i].e_ovf});
    end

    // Overflow on the 2-bit counter: five 0x01 words, then a clean 2-word frame.
    for (int i = 0; i < 5; i++) drive(1, 1, 8'h01, (i == 4), 0, 0);
    chk("ovf5_b", {20'd0, out_valid_b, out_lrc_b, out_parity_b, out_count_b, out_ovf_b},
                  {20'd0, 1'b1, 8'h01, 1'b1, 2'd3, 1'b1});
    chk("ovf5_a", {13'd0, out_lrc_a, out_parity_a, out_count_a, out_ovf_a},
                  {13'd0, 8'h01, 1'b1, 8'd5, 1'b0});
    drive(1, 0, 8'h00, 0, 0, 1);
    drive(1, 1, 8'h03, 0, 0, 1);
    drive(1, 1, 8'h04, 1, 0, 1);
    chk("after_ovf_b", {21'd0, out_valid_b, out_lrc_b, out_count_b, out_ovf_b},
                       {21'd0, 1'b1, 8'h07, 2'd2, 1'b0});

    // Overflow on the 8-bit counter: 260-word frame saturates at 255.
    drive(1, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 260; i++) drive(1, 1, 8'(i), (i == 259), 1, 0);
    chk("ovf260_a", {23'd0, out_valid_a, out_count_a, out_ovf_a},
                    {23'd0, 1'b1, 8'd255, 1'b1});
    drive(1, 0, 8'h00, 0, 0, 1);

    // Random traffic against the frame model.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
